hazard_unit_mc: RTL and testbench

- Parametrised successor to the pipeline hazard detector.
- Detects load-use hazards, including multi-cycle load latency, and branch-taken flushes.
- Tracks an in-flight multi-cycle mul/div unit with an internal FSM and down-counter, stalling only instructions that depend on it.
- Sits beside the ID stage; drives PC hold, IF/ID write-enable/flush and ID/EX flush.

---
 rtl/hazard_unit_mc_if.sv | 37 +++
 rtl/hazard_unit_mc.sv | 142 ++++++++++++++
 tb/tb_hazard_unit_mc.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_mc_if.sv
// rtl/hazard_unit_mc_if.sv - ID-stage hazard signal bundle between pipeline and hazard_unit_mc
interface hazard_unit_mc_if #(
   parameter int REG_W      = 5,
   parameter int STAT_WIDTH = 16
);
   logic [REG_W-1:0]      rsId;
   logic [REG_W-1:0]      rtId;
   logic                  rsUsedId;
   logic                  rtUsedId;
   logic                  memReadEx;
   logic [REG_W-1:0]      rtEx;
   logic                  branchTaken;
   logic                  mdStartId;
   logic                  mdUseId;
   logic                  pcStop;
   logic                  ifIdWrite;
   logic                  ifIdFlush;
   logic                  idExFlush;
   logic                  mdBusy;
   logic [STAT_WIDTH-1:0] stallCycles;
   logic [STAT_WIDTH-1:0] flushCount;

   // Pipeline side: presents ID/EX decode info, consumes stall/flush controls
   modport master (
      output rsId, rtId, rsUsedId, rtUsedId, memReadEx, rtEx,
             branchTaken, mdStartId, mdUseId,
      input  pcStop, ifIdWrite, ifIdFlush, idExFlush, mdBusy,
             stallCycles, flushCount
   );

   modport slave (
      input  rsId, rtId, rsUsedId, rtUsedId, memReadEx, rtEx,
             branchTaken, mdStartId, mdUseId,
      output pcStop, ifIdWrite, ifIdFlush, idExFlush, mdBusy,
             stallCycles, flushCount
   );
endinterface

// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - load-use / mul-div / branch hazard unit; HAZARD_STATS_EN adds stall and flush counters
module hazard_unit_mc #(
   parameter int REG_W             = 5,
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int MD_LATENCY        = 4,
   parameter int STAT_WIDTH        = 16
) (
   input  logic             clock,
   input  logic             reset,
   hazard_unit_mc_if.slave  hz
);
   localparam int MAX_CNT = (LOAD_STALL_CYCLES > MD_LATENCY) ? LOAD_STALL_CYCLES : MD_LATENCY;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);
   localparam bit LD_MULTI = (LOAD_STALL_CYCLES > 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] LD_INIT = CNT_W'(LOAD_STALL_CYCLES - 1);
   localparam logic [CNT_W-1:0] MD_INIT = CNT_W'(MD_LATENCY);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LD_STALL = 2'd1,
      MD_BUSY  = 2'd2
   } state_t;

   state_t           r_state, w_state_nxt;
   state_t           r_ret, w_ret_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [CNT_W-1:0] r_md_save, w_md_save_nxt;

   logic w_rs_match;
   logic w_rt_match;
   logic w_lu_haz;
   logic w_md_haz;
   logic w_stall;
   logic w_if_flush;

   assign w_rs_match = hz.rsUsedId && (hz.rsId == hz.rtEx);
   assign w_rt_match = hz.rtUsedId && (hz.rtId == hz.rtEx);
   assign w_lu_haz   = hz.memReadEx && (hz.rtEx != '0) && (w_rs_match || w_rt_match);
   assign w_md_haz   = (r_state == MD_BUSY) && (hz.mdUseId || hz.mdStartId);
   assign w_stall    = w_lu_haz || w_md_haz || (r_state == LD_STALL);
   assign w_if_flush = !w_stall && hz.branchTaken;

   assign hz.pcStop    = w_stall;
   assign hz.ifIdWrite = !w_stall;
   assign hz.idExFlush = w_stall;
   assign hz.ifIdFlush = w_if_flush;
   assign hz.mdBusy    = (r_state == MD_BUSY) || ((r_state == LD_STALL) && (r_ret == MD_BUSY));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_ret     <= IDLE;
         r_cnt     <= '0;
         r_md_save <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_ret     <= w_ret_nxt;
         r_cnt     <= w_cnt_nxt;
         r_md_save <= w_md_save_nxt;
      end
   end

   // r_cnt serves the active stall; r_md_save parks the mul/div count while a load stall borrows it
   always_comb begin
      w_state_nxt   = r_state;
      w_ret_nxt     = r_ret;
      w_cnt_nxt     = r_cnt;
      w_md_save_nxt = r_md_save;
      case (r_state)
         IDLE: begin
            if (w_lu_haz) begin
               if (LD_MULTI) begin
                  w_state_nxt = LD_STALL;
                  w_cnt_nxt   = LD_INIT;
                  w_ret_nxt   = IDLE;
               end
            end else if (hz.mdStartId) begin
               w_state_nxt = MD_BUSY;
               w_cnt_nxt   = MD_INIT;
            end
         end
         LD_STALL: begin
            if (r_cnt == CNT_ONE) begin
               w_state_nxt = r_ret;
               w_cnt_nxt   = (r_ret == MD_BUSY) ? r_md_save : '0;
            end else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
         end
         MD_BUSY: begin
            if (w_lu_haz && LD_MULTI) begin
               // The mul/div also counts this stalled cycle; if it retires now, resume to IDLE
               w_state_nxt = LD_STALL;
               w_cnt_nxt   = LD_INIT;
               if (r_cnt == CNT_ONE) begin
                  w_ret_nxt = IDLE;
               end else begin
                  w_ret_nxt     = MD_BUSY;
                  w_md_save_nxt = r_cnt - CNT_ONE;
               end
            end else if (r_cnt == CNT_ONE) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

`ifdef HAZARD_STATS_EN
   localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);

   logic [STAT_WIDTH-1:0] r_stall_cnt;
   logic [STAT_WIDTH-1:0] r_flush_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STAT_ONE;
         end
         if (w_if_flush && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + STAT_ONE;
         end
      end
   end

   assign hz.stallCycles = r_stall_cnt;
   assign hz.flushCount  = r_flush_cnt;
`else
   assign hz.stallCycles = '0;
   assign hz.flushCount  = '0;
`endif
endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb/tb_hazard_unit_mc.sv - randomized self-checking bench for hazard_unit_mc (single- and multi-cycle load builds)
module tb_hazard_unit_mc;
   localparam int LSC0 = 1;
   localparam int LSC1 = 3;
   localparam int MDL  = 4;
   localparam int SMAX0 = 65535;
   localparam int SMAX1 = 15;

   logic       clock;
   logic       reset;
   logic [4:0] rsId, rtId, rtEx;
   logic       rsUsedId, rtUsedId, memReadEx, branchTaken, mdStartId, mdUseId;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Reference state: remaining forced load bubbles, remaining mul/div busy cycles, stat counts
   int m0_ld, m0_md, m0_sc, m0_fc;
   int m1_ld, m1_md, m1_sc, m1_fc;

   hazard_unit_mc_if #(.REG_W(5), .STAT_WIDTH(16)) if0 ();
   hazard_unit_mc_if #(.REG_W(5), .STAT_WIDTH(4))  if1 ();

   assign if0.rsId = rsId;          assign if1.rsId = rsId;
   assign if0.rtId = rtId;          assign if1.rtId = rtId;
   assign if0.rsUsedId = rsUsedId;  assign if1.rsUsedId = rsUsedId;
   assign if0.rtUsedId = rtUsedId;  assign if1.rtUsedId = rtUsedId;
   assign if0.memReadEx = memReadEx; assign if1.memReadEx = memReadEx;
   assign if0.rtEx = rtEx;          assign if1.rtEx = rtEx;
   assign if0.branchTaken = branchTaken; assign if1.branchTaken = branchTaken;
   assign if0.mdStartId = mdStartId; assign if1.mdStartId = mdStartId;
   assign if0.mdUseId = mdUseId;    assign if1.mdUseId = mdUseId;

   hazard_unit_mc #(.REG_W(5), .LOAD_STALL_CYCLES(LSC0), .MD_LATENCY(MDL), .STAT_WIDTH(16)) u_dut0 (
      .clock(clock), .reset(reset), .hz(if0)
   );
   hazard_unit_mc #(.REG_W(5), .LOAD_STALL_CYCLES(LSC1), .MD_LATENCY(MDL), .STAT_WIDTH(4)) u_dut1 (
      .clock(clock), .reset(reset), .hz(if1)
   );

   logic [4:0] o0, o1;
   assign o0 = {if0.pcStop, if0.ifIdWrite, if0.ifIdFlush, if0.idExFlush, if0.mdBusy};
   assign o1 = {if1.pcStop, if1.ifIdWrite, if1.ifIdFlush, if1.idExFlush, if1.mdBusy};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic lu_haz();
      return memReadEx && (rtEx != 5'd0) &&
             ((rsUsedId && (rsId == rtEx)) || (rtUsedId && (rtId == rtEx)));
   endfunction

   // Expected {pcStop, ifIdWrite, ifIdFlush, idExFlush, mdBusy}
   function automatic logic [4:0] model_out(int ld, int md);
      logic st;
      st = lu_haz() || (ld > 0) || ((md > 0) && (ld == 0) && (mdUseId || mdStartId));
      return {st, !st, !st && branchTaken, st, md > 0};
   endfunction

   function automatic int exp_stat(int v);
`ifdef HAZARD_STATS_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   task automatic model_step(input int lsc, input int smax, inout int ld, inout int md,
                             inout int sc, inout int fc);
      logic [4:0] o;
      o = model_out(ld, md);
      if (o[4] && sc < smax) sc++;
      if (o[2] && fc < smax) fc++;
      if (ld > 0) begin
         ld--;
      end else if (md > 0) begin
         md--;
         if (lu_haz()) ld = lsc - 1;
      end else if (lu_haz()) begin
         ld = lsc - 1;
      end else if (mdStartId) begin
         md = MDL;
      end
   endtask

   task automatic model_reset();
      m0_ld = 0; m0_md = 0; m0_sc = 0; m0_fc = 0;
      m1_ld = 0; m1_md = 0; m1_sc = 0; m1_fc = 0;
   endtask

   task automatic clear_inputs();
      rsId = 0; rtId = 0; rtEx = 0;
      rsUsedId = 0; rtUsedId = 0; memReadEx = 0;
      branchTaken = 0; mdStartId = 0; mdUseId = 0;
   endtask

   task automatic tick();
      @(posedge clock);
      model_step(LSC0, SMAX0, m0_ld, m0_md, m0_sc, m0_fc);
      model_step(LSC1, SMAX1, m1_ld, m1_md, m1_sc, m1_fc);
      @(negedge clock);
   endtask

   task automatic drain();
      clear_inputs();
      repeat (6) tick();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      clear_inputs();
      model_reset();
      repeat (3) @(negedge clock);
      #1;
      total_cnt++;
      if (o0 !== 5'b01000) $display("FAIL reset_outs0 got %b want 01000", o0); else pass_cnt++;
      total_cnt++;
      if (o1 !== 5'b01000) $display("FAIL reset_outs1 got %b want 01000", o1); else pass_cnt++;
      total_cnt++;
      if (if0.stallCycles !== 16'd0 || if0.flushCount !== 16'd0)
         $display("FAIL reset_stats0 got %0d/%0d want 0/0", if0.stallCycles, if0.flushCount);
      else pass_cnt++;
      @(negedge clock);
      reset = 1'b1;
      #1;
   endtask

   task automatic test_load_use();
      drain();
      memReadEx = 1; rtEx = 8; rsId = 8; rsUsedId = 1;
      #1;
      total_cnt++;
      if (o0 !== 5'b10010) $display("FAIL lu_stall got %b want 10010", o0); else pass_cnt++;
      tick();
      clear_inputs();
      #1;
      total_cnt++;
      if (o0 !== 5'b01000) $display("FAIL lu_release got %b want 01000", o0); else pass_cnt++;
      drain();
      memReadEx = 1; rtEx = 0; rsId = 0; rsUsedId = 1; rtUsedId = 1;
      #1;
      total_cnt++;
      if (o0 !== 5'b01000) $display("FAIL lu_r0_dut0 got %b want 01000", o0); else pass_cnt++;
      total_cnt++;
      if (o1 !== 5'b01000) $display("FAIL lu_r0_dut1 got %b want 01000", o1); else pass_cnt++;
      tick();
   endtask

   task automatic test_multi_cycle_load();
      drain();
      memReadEx = 1; rtEx = 5; rtId = 5; rtUsedId = 1;
      for (int i = 0; i < 5; i++) begin
         #1;
         total_cnt++;
         if (o1 !== ((i < LSC1) ? 5'b10010 : 5'b01000))
            $display("FAIL mc_load_cyc%0d got %b want %b", i, o1, (i < LSC1) ? 5'b10010 : 5'b01000);
         else pass_cnt++;
         tick();
         clear_inputs();
      end
   endtask

   task automatic test_branch();
      drain();
      branchTaken = 1;
      #1;
      total_cnt++;
      if (o0 !== 5'b01100) $display("FAIL br_flush got %b want 01100", o0); else pass_cnt++;
      tick();
      clear_inputs();
      #1;
      total_cnt++;
      if (o0 !== 5'b01000) $display("FAIL br_one_cycle got %b want 01000", o0); else pass_cnt++;
      branchTaken = 1; memReadEx = 1; rtEx = 9; rsId = 9; rsUsedId = 1;
      #1;
      total_cnt++;
      if (o0 !== 5'b10010) $display("FAIL br_vs_stall got %b want 10010", o0); else pass_cnt++;
      tick();
      drain();
   endtask

   task automatic test_muldiv();
      drain();
      mdStartId = 1;
      #1;
      total_cnt++;
      if (o0 !== 5'b01000) $display("FAIL md_issue got %b want 01000", o0); else pass_cnt++;
      tick();
      mdStartId = 0; rsUsedId = 1; rsId = 3;
      #1;
      total_cnt++;
      if (o0 !== 5'b01001) $display("FAIL md_indep got %b want 01001", o0); else pass_cnt++;
      tick();
      mdUseId = 1;
      for (int i = 2; i <= MDL; i++) begin
         #1;
         total_cnt++;
         if (o0 !== 5'b10011) $display("FAIL md_use_bc%0d got %b want 10011", i, o0); else pass_cnt++;
         tick();
      end
      #1;
      total_cnt++;
      if (o0 !== 5'b01000) $display("FAIL md_retire got %b want 01000", o0); else pass_cnt++;
      tick();
      clear_inputs();
   endtask

   task automatic test_async_reset();
      drain();
      mdStartId = 1;
      #1;
      tick();
      mdStartId = 0; mdUseId = 1;
      tick();
      #1;
      total_cnt++;
      if (o0 !== 5'b10011) $display("FAIL ar_pre got %b want 10011", o0); else pass_cnt++;
      #2;
      reset = 1'b0;
      #1;
      total_cnt++;
      if (o0 !== 5'b01000) $display("FAIL ar_async0 got %b want 01000", o0); else pass_cnt++;
      total_cnt++;
      if (o1 !== 5'b01000) $display("FAIL ar_async1 got %b want 01000", o1); else pass_cnt++;
      model_reset();
      @(negedge clock);
      reset = 1'b1;
      #1;
      total_cnt++;
      if (o0 !== 5'b01000) $display("FAIL ar_idle got %b want 01000", o0); else pass_cnt++;
      tick();
      clear_inputs();
   endtask

   task automatic test_stats();
      int exp_sc, exp_fc;
`ifdef HAZARD_STATS_EN
      exp_sc = 15; exp_fc = 2;
`else
      exp_sc = 0;  exp_fc = 0;
`endif
      memReadEx = 1; rtEx = 7; rsId = 7; rsUsedId = 1;
      repeat (20) tick();
      drain();
      repeat (2) begin
         branchTaken = 1;
         tick();
         branchTaken = 0;
         tick();
      end
      #1;
      total_cnt++;
      if (if1.stallCycles !== 4'(exp_sc))
         $display("FAIL stat_sat got %0d want %0d", if1.stallCycles, exp_sc);
      else pass_cnt++;
      total_cnt++;
      if (if1.flushCount !== 4'(exp_fc))
         $display("FAIL stat_flush got %0d want %0d", if1.flushCount, exp_fc);
      else pass_cnt++;
      total_cnt++;
      if (if0.stallCycles !== 16'(exp_stat(m0_sc)))
         $display("FAIL stat_stall0 got %0d want %0d", if0.stallCycles, exp_stat(m0_sc));
      else pass_cnt++;
   endtask

   task automatic test_random();
      logic [4:0] e0, e1;
      for (int c = 0; c < 600; c++) begin
         rsId = 5'($urandom_range(0, 3));
         rtId = 5'($urandom_range(0, 3));
         rtEx = 5'($urandom_range(0, 3));
         rsUsedId = 1'($urandom_range(0, 1));
         rtUsedId = 1'($urandom_range(0, 1));
         memReadEx = ($urandom_range(0, 99) < 30);
         branchTaken = ($urandom_range(0, 99) < 20);
         mdStartId = ($urandom_range(0, 99) < 15);
         mdUseId = ($urandom_range(0, 99) < 15);
         #1;
         e0 = model_out(m0_ld, m0_md);
         e1 = model_out(m1_ld, m1_md);
         total_cnt++;
         if (o0 !== e0) $display("FAIL rnd_dut0 cyc%0d got %b want %b", c, o0, e0); else pass_cnt++;
         total_cnt++;
         if (o1 !== e1) $display("FAIL rnd_dut1 cyc%0d got %b want %b", c, o1, e1); else pass_cnt++;
         total_cnt++;
         if (if0.stallCycles !== 16'(exp_stat(m0_sc)) || if0.flushCount !== 16'(exp_stat(m0_fc)))
            $display("FAIL rnd_stats0 cyc%0d got %0d/%0d want %0d/%0d", c, if0.stallCycles,
                     if0.flushCount, exp_stat(m0_sc), exp_stat(m0_fc));
         else pass_cnt++;
         total_cnt++;
         if (if1.stallCycles !== 4'(exp_stat(m1_sc)) || if1.flushCount !== 4'(exp_stat(m1_fc)))
            $display("FAIL rnd_stats1 cyc%0d got %0d/%0d want %0d/%0d", c, if1.stallCycles,
                     if1.flushCount, exp_stat(m1_sc), exp_stat(m1_fc));
         else pass_cnt++;
         tick();
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_multi_cycle_load();
      test_branch();
      test_muldiv();
      test_async_reset();
      test_stats();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
